// File: rtl/inv_mix_col_seq.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms COLS_PER_CYCLE
// columns per clock and holds the result on a valid/ready output until taken.
module inv_mix_col_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state_o,
  output logic         busy_o
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("inv_mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  // Packed so that column c lives at index ~c (column 0 is the top word).
  logic [3:0][31:0] data_q, data_d;
  logic [3:0][31:0] res_q, res_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Returns {09*a, 0b*a, 0d*a, 0e*a}.
  function automatic logic [31:0] inv_terms(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [31:0] t0, t1, t2, t3;
    t0 = inv_terms(w[31:24]);
    t1 = inv_terms(w[23:16]);
    t2 = inv_terms(w[15:8]);
    t3 = inv_terms(w[7:0]);
    return {t0[7:0] ^ t1[23:16] ^ t2[15:8] ^ t3[31:24],
            t1[7:0] ^ t2[23:16] ^ t3[15:8] ^ t0[31:24],
            t2[7:0] ^ t3[23:16] ^ t0[15:8] ^ t1[31:24],
            t3[7:0] ^ t0[23:16] ^ t1[15:8] ^ t2[31:24]};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      data_q <= '0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      res_q  <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) state_d = BUSY;
        else            state_d = IDLE;
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   state_d = BUSY;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
        else             state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter step wraps it back to 0 on the last BUSY cycle.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    res_d  = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          data_d = in_state_i;
          cnt_d  = 2'd0;
        end else begin
          data_d = data_q;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          res_d[~(cnt_q + 2'(k))] = inv_mix_col(data_q[~(cnt_q + 2'(k))]);
        end
        cnt_d = cnt_q + CNT_STEP;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE:    in_ready_o = 1'b1;
      BUSY:    busy_o     = 1'b1;
      DONE: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: in_ready_o = 1'b0;
    endcase
  end

  assign out_state_o = res_q;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Scoreboard bench for inv_mix_col_seq: three instances (1, 2 and 4 columns per
// cycle), directed vectors, a decoupled monitor checking data and latency.
module tb_inv_mix_col_seq;

  typedef struct {
    int           dut;
    logic [127:0] data;
    int           lat;
  } exp_t;

  localparam logic [127:0] V2 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] E2 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] V3 = 128'hc6c6c6c6_01010101_00000000_ffffffff;
  localparam logic [127:0] V5 = {4{32'h4d7ebdf8}};
  localparam logic [127:0] E5 = {4{32'h2d26314c}};

  logic         clk;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc [3];
  logic vld_prev [3];

  inv_mix_col_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_state_i(in_state[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_state_o(out_state[0]), .busy_o(busy[0]));

  inv_mix_col_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_state_i(in_state[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_state_o(out_state[1]), .busy_o(busy[1]));

  inv_mix_col_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_state_i(in_state[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .out_state_o(out_state[2]), .busy_o(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: latency on out_valid rise, data on each output handshake.
  initial begin
    for (int d = 0; d < 3; d++) begin
      vld_prev[d] = 1'b0;
      acc_cyc[d]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          vld_prev[d] = 1'b0;
        end else begin
          if (in_valid[d] && in_ready[d]) acc_cyc[d] = cyc + 1;
          if (out_valid[d] && !vld_prev[d]) begin
            if (sb.size() == 0 || sb[0].dut != d) begin
              chk($sformatf("unexpected_valid_dut%0d", d), 128'(out_valid[d]), 128'(0));
            end else begin
              chk($sformatf("latency_dut%0d", d), 128'(cyc - acc_cyc[d]), 128'(sb[0].lat));
            end
          end
          if (out_valid[d] && out_ready[d]) begin
            if (sb.size() == 0 || sb[0].dut != d) begin
              chk($sformatf("unexpected_output_dut%0d", d), out_state[d], 128'(0));
            end else begin
              chk($sformatf("out_state_dut%0d", d), out_state[d], sb[0].data);
              void'(sb.pop_front());
            end
          end
          vld_prev[d] = out_valid[d];
        end
      end
    end
  end

  task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp,
                      input int lat, input bit push);
    int n = 0;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[d]) chk("send_timeout", 128'(in_ready[d]), 128'(1));
    in_valid[d] = 1'b1;
    in_state[d] = data;
    if (push) sb.push_back('{d, exp, lat});
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_state[d] = {4{$urandom}};
  endtask

  task automatic wait_valid(input int d);
    int n = 0;
    while (!out_valid[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid[d]) chk("wait_valid_timeout", 128'(out_valid[d]), 128'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      out_ready[d] = 1'b1;
    end
    #12 rst = 1'b0;
    #1;
    chk("por_in_ready", 128'(in_ready[0]), 128'(1));
    chk("por_out_valid", 128'(out_valid[0]), 128'(0));
    chk("por_busy", 128'(busy[0]), 128'(0));
    chk("por_out_state", out_state[0], 128'(0));
    @(posedge clk); #1;

    // Async reset pulsed mid-clock while a result is being held.
    out_ready[0] = 1'b0;
    send(0, V2, E2, 4, 1'b1);
    wait_valid(0);
    chk("pre_reset_out_state", out_state[0], E2);
    @(posedge clk); #2;
    sb.delete();
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", 128'(in_ready[0]), 128'(1));
    chk("async_rst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("async_rst_busy", 128'(busy[0]), 128'(0));
    chk("async_rst_out_state", out_state[0], 128'(0));
    #3 rst = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;

    // Known vector and fixed points, 1 column per cycle.
    send(0, V2, E2, 4, 1'b1);
    wait_done();
    send(0, V3, V3, 4, 1'b1);
    wait_done();

    // Back-to-back throughput: 4 + 2 cycles per state.
    send(0, V5, E5, 4, 1'b1);
    a0 = cyc;
    send(0, V2, E2, 4, 1'b1);
    chk("throughput_period", 128'(cyc - a0), 128'(6));
    wait_done();

    // Backpressure with a competing second input.
    out_ready[0] = 1'b0;
    send(0, V2, E2, 4, 1'b1);
    wait_valid(0);
    in_valid[0] = 1'b1;
    in_state[0] = V3;
    sb.push_back('{0, V3, 4});
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
      chk("bp_out_state", out_state[0], E2);
      chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", 128'(in_ready[0]), 128'(1));
    chk("bp_busy_after", 128'(busy[0]), 128'(0));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    in_state[0] = {4{$urandom}};
    chk("bp_second_accepted", 128'(busy[0]), 128'(1));
    wait_done();

    // Abort during the second BUSY cycle; no result may appear.
    send(0, V2, E2, 4, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy[0]), 128'(0));
    chk("abort_out_state", out_state[0], 128'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_valid", 128'(out_valid[0]), 128'(0));
    send(0, V5, E5, 4, 1'b1);
    wait_done();

    // Wider datapaths.
    send(1, V2, E2, 2, 1'b1);
    wait_done();
    send(1, V5, E5, 2, 1'b1);
    wait_done();
    send(2, V2, E2, 1, 1'b1);
    wait_done();
    send(2, V3, V3, 1, 1'b1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
